test_scoreboard: RTL

//  In-order bench scoreboard, the parametrised successor to the per-bench "models/display" sections.

---
 rtl/test_sb_pkg.sv | 18 +
 rtl/test_sb_fifo.sv | 55 +++++
 rtl/test_scoreboard.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/test_sb_pkg.sv
// Shared types for the in-order test scoreboard.
// Holds the scoreboard state enum and the bit positions inside the sticky err vector.
package test_sb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sb_state_t;

  localparam int unsigned ERR_W          = 4;
  localparam int unsigned ERR_MISMATCH   = 0;
  localparam int unsigned ERR_OVERFLOW   = 1;
  localparam int unsigned ERR_UNEXPECTED = 2;
  localparam int unsigned ERR_TIMEOUT    = 3;

endpackage

// File: rtl/test_sb_fifo.sv
// Synchronous FIFO holding the queued expected words of the scoreboard.
// Pointers carry one extra wrap bit so full and empty are told apart by the level.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata this cycle (caller never pushes at full unless popping too)
//   pop      : advance the head this cycle (caller never pops when empty)
//   wdata    : word to write
//   rdata    : head word, valid whenever level > 0
//   level    : number of stored words, 0..DEPTH
module test_sb_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; a push at full with a pop reuses the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/test_scoreboard.sv
// In-order scoreboard: queues expected words, pops and compares against DUT output words.
// Keeps saturating match/mismatch counters, sticky error flags, an idle watchdog and a
// drain/done sequence.
// Optional build macro SCOREBOARD_TRACE_EN adds a per-compare / per-event $display trace
// (simulation only); without it the module is fully synthesizable and STEP is unused.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   exp_valid/exp_data  : push an expected word
//   act_valid/act_data  : DUT output word to compare against the queue head
//   drain               : scenario finished, wait for the queue to empty
//   match_cnt/miss_cnt  : saturating compare counters
//   level               : queued expected words
//   err                 : sticky {timeout, unexpected, overflow, mismatch}
//   done / pass         : drain complete / drain complete with no error
module test_scoreboard
  import test_sb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STEP    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exp_valid,
  input  logic [WIDTH-1:0]       exp_data,
  input  logic                   act_valid,
  input  logic [WIDTH-1:0]       act_data,
  input  logic                   drain,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [CNT_W-1:0]       miss_cnt,
  output logic [$clog2(DEPTH):0] level,
  output logic [3:0]             err,
  output logic                   done,
  output logic                   pass
);

  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  sb_state_t          state_q, state_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [CNT_W-1:0]   miss_q, miss_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [LVL_W-1:0]   fifo_level;
  logic [WIDTH-1:0]   fifo_rdata;
  logic               fifo_push, fifo_pop;
  logic               empty, full, bypass;
  logic               cmp_valid, cmp_eq;
  logic [WIDTH-1:0]   cmp_exp;

  test_sb_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (exp_data),
    .rdata (fifo_rdata),
    .level (fifo_level)
  );

  assign empty = (fifo_level == '0);
  assign full  = (fifo_level == LVL_W'(DEPTH));

  // Queue control and compare operand selection.
  always_comb begin
    bypass    = exp_valid && act_valid && empty;
    fifo_pop  = act_valid && !empty;
    // At full a simultaneous pop frees the slot, so the push still goes in.
    fifo_push = exp_valid && !bypass && (!full || fifo_pop);
    cmp_valid = bypass || fifo_pop;
    cmp_exp   = bypass ? exp_data : fifo_rdata;
    cmp_eq    = (cmp_exp == act_data);
  end

  // Counters, flags, watchdog and state next values.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = err_q;
    idle_d  = idle_q;

    if (cmp_valid) begin
      if (cmp_eq) begin
        if (match_q != '1) match_d = match_q + CNT_W'(1);
      end else begin
        if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
        err_d[ERR_MISMATCH] = 1'b1;
      end
    end

    // A full queue with act_valid always pops, so only a lone push overflows.
    if (exp_valid && full && !act_valid) err_d[ERR_OVERFLOW]   = 1'b1;
    if (act_valid && empty && !exp_valid) err_d[ERR_UNEXPECTED] = 1'b1;

    if (act_valid || empty) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(TIMEOUT)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
    if (idle_d == IDLE_W'(TIMEOUT)) err_d[ERR_TIMEOUT] = 1'b1;

    case (state_q)
      IDLE: begin
        if (drain)                       state_d = DONE;
        else if (exp_valid || act_valid) state_d = RUN;
      end
      RUN: begin
        if (drain) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty || err_q[ERR_TIMEOUT]) state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign match_cnt = match_q;
  assign miss_cnt  = miss_q;
  assign level     = fifo_level;
  assign err       = err_q;
  assign done      = done_q;
  assign pass      = pass_q;

`ifdef SCOREBOARD_TRACE_EN
  // Simulation trace of compares, newly raised error bits and DONE entry.
  always @(posedge clk) begin
    if (!rst) begin
      if (cmp_valid)
        $display("%d: | %h %h | %s |", $time / STEP, cmp_exp, act_data, cmp_eq ? "OK" : "NG");
      for (int i = 0; i < int'(ERR_W); i++) begin
        if (err_d[i] && !err_q[i]) $display("%d: err[%0d] set", $time / STEP, i);
      end
      if ((state_d == DONE) && (state_q != DONE))
        $display("%d: DONE pass=%0d", $time / STEP, pass_d);
    end
  end
`endif

endmodule
